// File: rtl/cpu_bus_master_if.sv
// cpu_bus_master_if: request/response and cartridge-side bus signals of the CPU bus master
interface cpu_bus_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic        req_rw;
  logic [7:0]  req_wdata;
  logic        resp_valid;
  logic [7:0]  resp_rdata;
  logic        m2;
  logic        romsel;
  logic        cpu_rw;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_data_oe;
  logic [7:0]  cpu_data_in;
  logic        irq;
  logic        irq_seen;
  logic        irq_clear;
  modport master (
    input  req_valid, req_addr, req_rw, req_wdata, cpu_data_in, irq, irq_clear,
    output req_ready, resp_valid, resp_rdata, m2, romsel, cpu_rw, cpu_addr,
           cpu_data_out, cpu_data_oe, irq_seen
  );
  modport slave (
    output req_valid, req_addr, req_rw, req_wdata, cpu_data_in, irq, irq_clear,
    input  req_ready, resp_valid, resp_rdata, m2, romsel, cpu_rw, cpu_addr,
           cpu_data_out, cpu_data_oe, irq_seen
  );
endinterface

// File: rtl/cpu_bus_master.sv
// cpu_bus_master: m2-paced CPU bus cycle generator, one transaction per bus cycle; CPU_BUS_MASTER_IRQ_SYNC_EN enables the /IRQ latch
module cpu_bus_master #(
  parameter int HALF_CLKS = 6
) (
  input  logic clk,
  input  logic reset,
  cpu_bus_master_if.master bus
);
  typedef enum logic {LO, HI} phase_t;
  localparam logic [7:0] LAST = 8'(HALF_CLKS - 1);
  phase_t     phase, phase_n;
  logic [7:0] cnt, cnt_n;
  logic       act, a15, rw_q, resp_q;
  logic [14:0] addr_q;
  logic [7:0] wdata_q, rdata_q;
  logic       last, start, hi_end;
  assign last   = cnt == LAST;
  assign start  = phase == LO && cnt == 8'd0;
  assign hi_end = phase == HI && last;
  // phase/counter state register
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= LO;
      cnt   <= 8'd0;
    end else begin
      phase <= phase_n;
      cnt   <= cnt_n;
    end
  end
  // free-running m2 half-phase sequencing
  always_comb begin
    phase_n = last ? (phase == LO ? HI : LO) : phase;
    cnt_n   = last ? 8'd0 : cnt + 8'd1;
  end
  // transaction capture at slot open, read capture and response at end of HI
  always_ff @(posedge clk) begin
    if (reset) begin
      act     <= 1'b0;
      a15     <= 1'b0;
      rw_q    <= 1'b1;
      addr_q  <= 15'h0;
      wdata_q <= 8'h0;
      rdata_q <= 8'h0;
      resp_q  <= 1'b0;
    end else begin
      resp_q <= hi_end && act;
      if (hi_end && act && rw_q) rdata_q <= bus.cpu_data_in;
      if (start) begin
        act    <= bus.req_valid;
        a15    <= bus.req_valid & bus.req_addr[15];
        rw_q   <= bus.req_valid ? bus.req_rw : 1'b1;
        addr_q <= bus.req_valid ? bus.req_addr[14:0] : 15'h0;
        if (bus.req_valid) wdata_q <= bus.req_wdata;
      end
    end
  end
  assign bus.req_ready    = start;
  assign bus.resp_valid   = resp_q;
  assign bus.resp_rdata   = rdata_q;
  assign bus.m2           = phase == HI;
  assign bus.romsel       = ~(bus.m2 & a15);
  assign bus.cpu_rw       = rw_q;
  assign bus.cpu_addr     = addr_q;
  assign bus.cpu_data_out = wdata_q;
  assign bus.cpu_data_oe  = bus.m2 & act & ~rw_q;
`ifdef CPU_BUS_MASTER_IRQ_SYNC_EN
  logic s1, s2, seen;
  // /IRQ synchronizer and sticky flag, set wins over clear
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      seen <= 1'b0;
    end else begin
      s1   <= bus.irq;
      s2   <= s1;
      seen <= ~s2 ? 1'b1 : bus.irq_clear ? 1'b0 : seen;
    end
  end
  assign bus.irq_seen = seen;
`else
  logic unused_irq;
  assign unused_irq   = bus.irq & bus.irq_clear;
  assign bus.irq_seen = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_bus_master.sv
// tb_cpu_bus_master: directed table-driven bench for cpu_bus_master at HALF_CLKS=6
module tb_cpu_bus_master;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  cpu_bus_master_if bus();
  cpu_bus_master #(.HALF_CLKS(6)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic        valid;
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  din;
    logic [14:0] e_addr;
    logic        e_rw;
    logic        e_romsel;
    logic        e_oe;
    logic [7:0]  e_rdata;
  } vec_t;
  vec_t vt [6];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask
  task automatic run(input vec_t v);
    chk("ready_at_start", bus.req_ready, 1);
    bus.req_valid = v.valid;
    bus.req_rw = v.rw;
    bus.req_addr = v.addr;
    bus.req_wdata = v.wdata;
    bus.cpu_data_in = v.din;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      if (k < 12) begin
        chk("m2", bus.m2, k >= 6);
        chk("ready_low", bus.req_ready, 0);
        chk("cpu_addr", bus.cpu_addr, v.e_addr);
        chk("cpu_rw", bus.cpu_rw, v.e_rw);
        chk("romsel", bus.romsel, k >= 6 ? v.e_romsel : 1'b1);
        chk("oe", bus.cpu_data_oe, k >= 6 ? v.e_oe : 1'b0);
        chk("resp_quiet", bus.resp_valid, 0);
        if (k >= 6 && v.e_oe) chk("data_out", bus.cpu_data_out, v.wdata);
      end else begin
        chk("resp_valid", bus.resp_valid, v.valid);
        chk("resp_rdata", bus.resp_rdata, v.e_rdata);
        chk("ready_next", bus.req_ready, 1);
      end
    end
  endtask
  initial begin
    vt[0] = '{1'b1, 1'b1, 16'h8123, 8'h00, 8'hA5, 15'h0123, 1'b1, 1'b0, 1'b0, 8'hA5};
    vt[1] = '{1'b1, 1'b0, 16'h6000, 8'h3C, 8'h11, 15'h6000, 1'b0, 1'b1, 1'b1, 8'hA5};
    vt[2] = '{1'b0, 1'b0, 16'hFFFF, 8'h99, 8'h22, 15'h0000, 1'b1, 1'b1, 1'b0, 8'hA5};
    vt[3] = '{1'b1, 1'b1, 16'h7FFF, 8'h00, 8'h5A, 15'h7FFF, 1'b1, 1'b1, 1'b0, 8'h5A};
    vt[4] = '{1'b1, 1'b0, 16'hFFFF, 8'hC3, 8'h33, 15'h7FFF, 1'b0, 1'b0, 1'b1, 8'h5A};
    vt[5] = '{1'b1, 1'b1, 16'h8000, 8'h00, 8'h00, 15'h0000, 1'b1, 1'b0, 1'b0, 8'h00};
    bus.req_valid = 1'b0;
    bus.req_rw = 1'b1;
    bus.req_addr = 16'h0;
    bus.req_wdata = 8'h0;
    bus.cpu_data_in = 8'h0;
    bus.irq = 1'b1;
    bus.irq_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_m2", bus.m2, 0);
    chk("rst_romsel", bus.romsel, 1);
    chk("rst_rw", bus.cpu_rw, 1);
    chk("rst_addr", bus.cpu_addr, 0);
    chk("rst_dout", bus.cpu_data_out, 0);
    chk("rst_oe", bus.cpu_data_oe, 0);
    chk("rst_resp", bus.resp_valid, 0);
    chk("rst_rdata", bus.resp_rdata, 0);
    chk("rst_irq_seen", bus.irq_seen, 0);
    reset = 1'b0;
    for (int i = 0; i < 48; i++) begin
      if (i > 0) @(negedge clk);
      chk("idle_m2", bus.m2, (i % 12) >= 6);
      chk("idle_ready", bus.req_ready, (i % 12) == 0);
      chk("idle_romsel", bus.romsel, 1);
      chk("idle_addr", bus.cpu_addr, 0);
      chk("idle_oe", bus.cpu_data_oe, 0);
      chk("idle_resp", bus.resp_valid, 0);
    end
    @(negedge clk);
    for (int i = 0; i < 6; i++) run(vt[i]);
    bus.req_valid = 1'b1;
    bus.req_rw = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk("b2b_ready", bus.req_ready, 1);
      bus.req_addr = 16'h8000 + 16'(j);
      bus.req_wdata = 8'h40 + 8'(j);
      if (j == 3) begin
        @(negedge clk);
        bus.req_valid = 1'b0;
      end else @(negedge clk);
      for (int k = 1; k < 12; k++) begin
        if (k > 1) @(negedge clk);
        chk("b2b_resp_quiet", bus.resp_valid, 0);
        if (k == 6) begin
          chk("b2b_addr", bus.cpu_addr, 15'(j));
          chk("b2b_romsel", bus.romsel, 0);
          chk("b2b_data", bus.cpu_data_out, 8'h40 + 8'(j));
          chk("b2b_oe", bus.cpu_data_oe, 1);
        end
      end
      @(negedge clk);
      chk("b2b_resp", bus.resp_valid, 1);
      chk("b2b_rdata", bus.resp_rdata, 8'h00);
    end
    bus.req_valid = 1'b1;
    bus.req_rw = 1'b1;
    bus.req_addr = 16'h8123;
    bus.cpu_data_in = 8'h77;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_hi", bus.m2, 1);
    chk("abort_romsel_hi", bus.romsel, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_m2", bus.m2, 0);
    chk("abort_romsel", bus.romsel, 1);
    chk("abort_rw", bus.cpu_rw, 1);
    chk("abort_addr", bus.cpu_addr, 0);
    chk("abort_oe", bus.cpu_data_oe, 0);
    chk("abort_resp", bus.resp_valid, 0);
    chk("abort_rdata", bus.resp_rdata, 0);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk("post_abort_quiet", bus.resp_valid, 0);
      chk("post_abort_ready", bus.req_ready, k == 0);
      @(negedge clk);
    end
    run(vt[0]);
    bus.irq = 1'b0;
    @(negedge clk);
    bus.irq = 1'b1;
    @(negedge clk);
    @(negedge clk);
`ifdef CPU_BUS_MASTER_IRQ_SYNC_EN
    chk("irq_seen_set", bus.irq_seen, 1);
    bus.irq_clear = 1'b1;
    @(negedge clk);
    bus.irq_clear = 1'b0;
    chk("irq_seen_clr", bus.irq_seen, 0);
`else
    chk("irq_seen_off", bus.irq_seen, 0);
    bus.irq_clear = 1'b1;
    @(negedge clk);
    bus.irq_clear = 1'b0;
    chk("irq_seen_off2", bus.irq_seen, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_bus_master.md
CPU_BUS_MASTER -- requirements
Module: cpu_bus_master

Interface
REQ-001 SHALL have parameter HALF_CLKS, default 6, meaning clk periods per m2 phase (legal range 2..255).
REQ-002 SHALL have ports: clk  in  1  system clock (all logic on rising edge).
REQ-003 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have: req_valid  in  1  request present; req_ready  out  1  request slot open this clk.
REQ-005 SHALL have: req_addr  in  16  CPU address; req_rw  in  1  1=read, 0=write; req_wdata  in  8  write data.
REQ-006 SHALL have: resp_valid  out  1  transaction completed pulse; resp_rdata  out  8  read data.
REQ-007 SHALL have: m2  out  1  CPU phi2; romsel  out  1  active-low /ROMSEL; cpu_rw  out  1  R/W.
REQ-008 SHALL have: cpu_addr  out  15  CPU A14..A0; cpu_data_out  out  8; cpu_data_oe  out  1; cpu_data_in  in  8.
REQ-009 SHALL have: irq  in  1  cartridge /IRQ (active low); irq_seen  out  1  latched IRQ flag; irq_clear  in  1  clears flag.

Function
REQ-010 SHALL run m2 continuously: LO phase (m2=0) HALF_CLKS clks, then HI phase (m2=1) HALF_CLKS clks; one bus cycle = 2*HALF_CLKS clks, no gaps.
REQ-011 SHALL use phase counter cnt 0..HALF_CLKS-1, wrapping to 0 and toggling phase at HALF_CLKS-1.
REQ-012 SHALL assert req_ready exactly during LO clk cnt=0 of every bus cycle, never otherwise.
REQ-013 SHALL accept a request when req_valid & req_ready at a clk edge; addr/rw/wdata captured at that edge.
REQ-014 SHALL drive captured cpu_addr=addr[14:0] and cpu_rw=rw from LO cnt=1 through end of HI phase.
REQ-015 SHALL drive romsel = ~(m2 & addr[15]) for accepted cycles, i.e. low only during HI phase with A15=1.
REQ-016 SHALL, for writes, drive cpu_data_out=wdata with cpu_data_oe=1 for the whole HI phase; oe=0 at all other times and for reads.
REQ-017 SHALL, for reads, capture cpu_data_in into resp_rdata at edge ending HI cnt=HALF_CLKS-1.
REQ-018 SHALL pulse resp_valid for one clk, coincident with next cycle's LO cnt=0 (same clk req_ready is high); resp_rdata held until next read completes; writes leave resp_rdata unchanged.
REQ-019 SHALL sustain back-to-back transfers: one transaction per bus cycle when req_valid held.
REQ-020 SHALL run an idle (dummy-read) cycle when no request accepted: cpu_addr=15'h0000, cpu_rw=1, romsel=1, oe=0, no resp_valid.
REQ-021 SHALL never change cpu_addr, cpu_rw or cpu_data_out while m2=1.

Reset
REQ-022 SHALL on reset: m2=0, romsel=1, cpu_rw=1, cpu_addr=0, cpu_data_out=0, cpu_data_oe=0, resp_valid=0, resp_rdata=0, irq_seen=0, phase=LO, cnt=0.
REQ-023 SHALL abort any in-flight transaction on reset mid-cycle with no resp_valid; first clk after release is LO cnt=0 with req_ready=1.

Configuration
REQ-024 SHALL, with macro CPU_BUS_MASTER_IRQ_SYNC_EN defined, pass irq through a 2-flop synchronizer and set irq_seen when synchronized irq=0, clear on irq_clear (set wins if both same clk).
REQ-025 SHALL, without CPU_BUS_MASTER_IRQ_SYNC_EN, tie irq_seen=0 and ignore irq and irq_clear.

Verification
REQ-026 Reset then idle 48 clks (HALF_CLKS=6) -> m2 period 12 clks, 50% duty, romsel=1, cpu_addr=0, req_ready pulse every 12 clks.
REQ-027 Read 0x8123, cpu_data_in=0xA5 -> romsel low 6 clks in HI, cpu_addr=0x0123, resp_valid one clk with resp_rdata=0xA5, 12 clks after accept.
REQ-028 Write 0x6000<-0x3C -> romsel=1 throughout, cpu_rw=0, oe=1 only during 6 HI clks, data 0x3C, resp_valid pulse, resp_rdata unchanged.
REQ-029 Four back-to-back writes 0x8000..0x8003 with req_valid held -> accepted on four consecutive req_ready pulses, four resp_valid pulses 12 clks apart.
REQ-030 Reset asserted at HI cnt=3 of a read -> no resp_valid; outputs at reset values next clk; new read after release completes normally.
REQ-031 With macro: irq low 1 clk -> irq_seen=1 within 3 clks; irq_clear -> 0; without macro irq_seen stays 0.
